// File: rtl/core_pipe_wbq_pkg.sv
// Shared encodings for the writeback queue:
// FSM states, memory access sizes and trap causes.
package core_pipe_wbq_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        FLUSH = 2'd2
    } wbq_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    localparam logic [5:0] CAUSE_LD_FAULT = 6'd5;
    localparam logic [5:0] CAUSE_ST_FAULT = 6'd7;

endpackage

// File: rtl/core_lsu_ralign.sv
// Load data aligner: shift by byte offset,
// mask to access size, optional sign extension.
module core_lsu_ralign
    import core_pipe_wbq_pkg::*;
#(
    parameter  int XLEN = 64,
    localparam int OW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [OW-1:0]   off,
    input  logic [1:0]      size,
    input  logic            sext,
    output logic [XLEN-1:0] data
);

    localparam logic [XLEN-1:0] ONES = '1;

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] msk;
    logic [XLEN-1:0] top;
    logic            neg;

    // Double at XLEN=32 falls to a full-width word mask.
    always_comb begin
        sh  = rdata >> {off, 3'b000};
        msk = ONES;
        unique case (size)
            SZ_B:    msk = ONES >> (XLEN - 8);
            SZ_H:    msk = ONES >> (XLEN - 16);
            SZ_W:    msk = ONES >> (XLEN - 32);
            default: msk = ONES;
        endcase
        top  = msk ^ (msk >> 1);
        neg  = sext && ((sh & top) != '0);
        data = (sh & msk) | (neg ? ~msk : '0);
    end

endmodule

// File: rtl/core_pipe_wbq.sv
// In-order writeback queue with load/store trap handling.
// Optional CORE_WBQ_TRACE_EN adds retirement trace ports.
module core_pipe_wbq
    import core_pipe_wbq_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            s3_valid,
    output logic            s3_ready,
    input  logic [XLEN-1:0] s3_pc,
    input  logic [31:0]     s3_instr,
    input  logic [XLEN-1:0] s3_wdata,
    input  logic [4:0]      s3_rd,
    input  logic            s3_wen,
    input  logic            s3_load,
    input  logic            s3_store,
    input  logic [1:0]      s3_size,
    input  logic            s3_sext,
    input  logic            dmem_rsp_valid,
    input  logic            dmem_rsp_err,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            cf_valid,
    input  logic            cf_ack,
    output logic [XLEN-1:0] cf_target,
    input  logic [XLEN-1:0] mtvec_base,
    output logic [5:0]      trap_cause,
    output logic [XLEN-1:0] trap_mtval,
    output logic [XLEN-1:0] trap_pc,
`ifdef CORE_WBQ_TRACE_EN
    output logic            trs_valid,
    output logic [XLEN-1:0] trs_pc,
    output logic [31:0]     trs_instr,
`endif
    output logic            instr_ret
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(XLEN / 8);

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_wdata [DEPTH];
    logic [4:0]      q_rd    [DEPTH];
    logic [1:0]      q_size  [DEPTH];
    logic            q_wen   [DEPTH];
    logic            q_load  [DEPTH];
    logic            q_store [DEPTH];
    logic            q_sext  [DEPTH];

    logic [PW-1:0] hd_ptr;
    logic [PW-1:0] tl_ptr;
    logic [CW-1:0] q_cnt;
    logic [CW-1:0] mem_cnt;
    logic [CW-1:0] drn_cnt;
    logic [CW-1:0] drn_nx;

    wbq_state_e state;
    wbq_state_e state_nx;

    logic            enq;
    logic            retire;
    logic            flush;
    logic            h_vld;
    logic            h_mem;
    logic            s3_mem;
    logic [XLEN-1:0] ld_data;

    assign h_vld    = q_cnt != '0;
    assign h_mem    = q_load[hd_ptr] | q_store[hd_ptr];
    assign s3_mem   = s3_load | s3_store;
    assign s3_ready = (q_cnt != CW'(DEPTH)) && (state == RUN);
    assign enq      = s3_valid & s3_ready;

    // Entry payload; the head never aliases the tail being written.
    always_ff @(posedge g_clk) begin
        if (enq) begin
            q_pc[tl_ptr]    <= s3_pc;
            q_wdata[tl_ptr] <= s3_wdata;
            q_rd[tl_ptr]    <= s3_rd;
            q_size[tl_ptr]  <= s3_size;
            q_wen[tl_ptr]   <= s3_wen;
            q_load[tl_ptr]  <= s3_load;
            q_store[tl_ptr] <= s3_store;
            q_sext[tl_ptr]  <= s3_sext;
        end
    end

    // Pointers and occupancy; a trap ack empties the queue.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            hd_ptr  <= '0;
            tl_ptr  <= '0;
            q_cnt   <= '0;
            mem_cnt <= '0;
        end else if (flush) begin
            hd_ptr  <= '0;
            tl_ptr  <= '0;
            q_cnt   <= '0;
            mem_cnt <= '0;
        end else begin
            if (enq)
                tl_ptr <= tl_ptr + PW'(1);
            if (retire)
                hd_ptr <= hd_ptr + PW'(1);
            q_cnt   <= q_cnt + CW'(enq) - CW'(retire);
            mem_cnt <= mem_cnt
                     + CW'(enq && s3_mem)
                     - CW'(retire && h_mem);
        end
    end

    // FSM state and drain counter registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state   <= RUN;
            drn_cnt <= '0;
        end else begin
            state   <= state_nx;
            drn_cnt <= drn_nx;
        end
    end

    // Next state, retire and flush decisions.
    always_comb begin
        state_nx = state;
        drn_nx   = drn_cnt;
        retire   = 1'b0;
        flush    = 1'b0;
        cf_valid = 1'b0;
        unique case (state)
            RUN: begin
                if (h_vld) begin
                    if (!h_mem)
                        retire = 1'b1;
                    else if (dmem_rsp_valid && dmem_rsp_err)
                        state_nx = TRAP;
                    else if (dmem_rsp_valid)
                        retire = 1'b1;
                end
            end
            TRAP: begin
                cf_valid = 1'b1;
                if (cf_ack) begin
                    flush    = 1'b1;
                    drn_nx   = mem_cnt - CW'(1);
                    state_nx = (mem_cnt == CW'(1)) ? RUN : FLUSH;
                end
            end
            FLUSH: begin
                if (dmem_rsp_valid) begin
                    drn_nx = drn_cnt - CW'(1);
                    if (drn_cnt == CW'(1))
                        state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    core_lsu_ralign #(
        .XLEN (XLEN)
    ) u_ralign (
        .rdata (dmem_rsp_rdata),
        .off   (q_wdata[hd_ptr][OW-1:0]),
        .size  (q_size[hd_ptr]),
        .sext  (q_sext[hd_ptr]),
        .data  (ld_data)
    );

    assign instr_ret = retire | flush;
    assign rd_wen    = retire & q_wen[hd_ptr]
                     & (q_rd[hd_ptr] != 5'd0);
    assign rd_addr   = q_rd[hd_ptr];
    assign rd_wdata  = q_load[hd_ptr] ? ld_data
                                      : q_wdata[hd_ptr];

    assign cf_target  = cf_valid ? mtvec_base : '0;
    assign trap_mtval = cf_valid ? q_wdata[hd_ptr] : '0;
    assign trap_pc    = cf_valid ? q_pc[hd_ptr] : '0;
    assign trap_cause = !cf_valid      ? 6'd0 :
                        q_load[hd_ptr] ? CAUSE_LD_FAULT
                                       : CAUSE_ST_FAULT;

`ifdef CORE_WBQ_TRACE_EN
    logic [31:0] q_instr [DEPTH];

    // Instruction words kept only for the trace port.
    always_ff @(posedge g_clk) begin
        if (enq)
            q_instr[tl_ptr] <= s3_instr;
    end

    assign trs_valid = instr_ret;
    assign trs_pc    = q_pc[hd_ptr];
    assign trs_instr = q_instr[hd_ptr];
`else
    logic unused_instr;
    assign unused_instr = ^s3_instr;
`endif

endmodule
